pll_reset_ctrl: RTL



---
 rtl/pll_pkg.sv | 24 ++
 rtl/sync2.sv | 24 ++
 rtl/pll_reset_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/pll_pkg.sv
// Shared types and default timing for the PLL reset controller.
package pll_pkg;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    WAIT   = 2'd1,
    STABLE = 2'd2,
    RUN    = 2'd3
  } pll_state_t;

  // Defaults sized for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_HOLD     = 16;     // 320 ns PLL reset pulse
  localparam int unsigned DEF_LOCK_TIMEOUT = 65536;  // ~1.3 ms to acquire lock
  localparam int unsigned DEF_LOCK_STABLE  = 1024;   // ~20 us of clean lock
  localparam int unsigned DEF_CNT_W        = 8;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for a single asynchronous level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases a synchronous system reset. Retries on timeout, re-sequences on
// lock loss or software request, and counts both kinds of event.
module pll_reset_ctrl
  import pll_pkg::*;
#(
  parameter int unsigned RST_HOLD     = DEF_RST_HOLD,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int unsigned LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             soft_rst_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] relock_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam int unsigned CW = $clog2(max3(RST_HOLD, LOCK_TIMEOUT, LOCK_STABLE)) + 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);

  logic          lk_s;
  pll_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          timeout_hit, relock_hit;
  logic          pll_rst_nxt, sys_rst_nxt, ready_nxt;

  sync2 #(.RST_VAL(1'b0)) u_lk_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk_s)
  );

  // State and shared cycle counter.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOLD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; soft request overrides everything, lock beats timeout in WAIT.
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    relock_hit  = 1'b0;
    if (soft_rst_req) begin
      state_nxt = HOLD;
    end else begin
      case (state)
        HOLD:   if (cnt == HOLD_LAST) state_nxt = WAIT;
        WAIT: begin
          if (lk_s) begin
            state_nxt = STABLE;
          end else if (cnt == TO_LAST) begin
            state_nxt   = HOLD;
            timeout_hit = 1'b1;
          end
        end
        STABLE: begin
          if (!lk_s)                 state_nxt = WAIT;
          else if (cnt == STB_LAST)  state_nxt = RUN;
        end
        RUN: begin
          if (!lk_s) begin
            state_nxt  = HOLD;
            relock_hit = 1'b1;
          end
        end
        default: state_nxt = HOLD;
      endcase
    end
    // Counter restarts on any transition or soft request; idle in RUN.
    if (soft_rst_req || (state_nxt != state) || (state == RUN)) cnt_nxt = '0;
    else                                                         cnt_nxt = cnt + CW'(1);
  end

  // Output values for the coming state, registered below.
  always_comb begin
    pll_rst_nxt = (state_nxt == HOLD);
    sys_rst_nxt = (state_nxt != RUN);
    ready_nxt   = (state_nxt == RUN);
  end

  // Registered outputs and saturating event counters.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      relock_cnt  <= '0;
      timeout_cnt <= '0;
    end else begin
      pll_rst <= pll_rst_nxt;
      sys_rst <= sys_rst_nxt;
      ready   <= ready_nxt;
      if (relock_hit && (relock_cnt != '1))   relock_cnt  <= relock_cnt + CNT_W'(1);
      if (timeout_hit && (timeout_cnt != '1)) timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end

endmodule
